// File: rtl/dcc_pkg.sv
// dcc_pkg: shared types and owner codes for the DCC bus arbiter
package dcc_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_TURN, ST_GNT_S, ST_GNT_E, ST_RET} state_t;
   typedef enum logic {REQR_SLV, REQR_EXT} req_t;
   localparam logic [1:0] OWN_MST  = 2'd0;
   localparam logic [1:0] OWN_SLV  = 2'd1;
   localparam logic [1:0] OWN_EXT  = 2'd2;
   localparam logic [1:0] OWN_NONE = 2'd3;
endpackage

// File: rtl/dcc_bus_arbiter.sv
// dcc_bus_arbiter: sequences SH-2 system bus ownership between master, slave SH-2 and external requester
module dcc_bus_arbiter
   import dcc_pkg::*;
#(
   parameter int TURN_CYC    = 2,
   parameter int BGR_TIMEOUT = 255
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CE_R,
   input  logic       BREQ_N,
   input  logic       EXBREQ_N,
   input  logic       BGR_N,
   output logic       BRLS_N,
   output logic       BACK_N,
   output logic       EXBACK_N,
   output logic [1:0] OWNER,
   output logic       ARB_ERR
);
   localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
   localparam logic [7:0] TO_MAX    = 8'(BGR_TIMEOUT);

   state_t     state_q, state_d;
   req_t       last_q, last_d;
   logic [3:0] turn_q, turn_d;
   logic [7:0] to_q, to_d;
   logic       brls_n_q, brls_n_d, back_n_q, back_n_d, exback_n_q, exback_n_d;
   logic       arb_err_q, arb_err_d;
   logic [1:0] owner_q, owner_d;
   logic       s_req, e_req;

   assign s_req = ~BREQ_N;
   assign e_req = ~EXBREQ_N;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         last_q     <= REQR_EXT;
         turn_q     <= '0;
         to_q       <= '0;
         brls_n_q   <= 1'b1;
         back_n_q   <= 1'b1;
         exback_n_q <= 1'b1;
         owner_q    <= OWN_MST;
         arb_err_q  <= 1'b0;
      end else if (CE_R) begin
         state_q    <= state_d;
         last_q     <= last_d;
         turn_q     <= turn_d;
         to_q       <= to_d;
         brls_n_q   <= brls_n_d;
         back_n_q   <= back_n_d;
         exback_n_q <= exback_n_d;
         owner_q    <= owner_d;
         arb_err_q  <= arb_err_d;
      end
   end

   // A timeout raises ARB_ERR for one cycle while still in REQ; the following edge releases to RET.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      turn_d    = turn_q;
      to_d      = to_q;
      arb_err_d = 1'b0;
      case (state_q)
         ST_IDLE:  if (s_req || e_req) begin
                      state_d = ST_REQ;
                      to_d    = '0;
                   end
         ST_REQ:   if ((!s_req && !e_req) || to_q == TO_MAX) state_d = ST_RET;
                   else if (!BGR_N) state_d = ST_TURN;
                   else begin
                      to_d      = (to_q == 8'hFF) ? to_q : to_q + 8'd1;
                      arb_err_d = (to_q == TO_MAX - 8'd1);
                   end
         ST_TURN:  if (turn_q != TURN_LAST) turn_d = turn_q + 4'd1;
                   else if (s_req && (!e_req || last_q == REQR_EXT)) state_d = ST_GNT_S;
                   else if (e_req) state_d = ST_GNT_E;
                   else state_d = ST_RET;
         ST_GNT_S: if (!s_req) state_d = e_req ? ST_TURN : ST_RET;
         ST_GNT_E: if (!e_req) state_d = s_req ? ST_TURN : ST_RET;
         ST_RET:   if (BGR_N) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (state_d == ST_TURN && state_q != ST_TURN) turn_d = '0;
      if (state_d == ST_GNT_S) last_d = REQR_SLV;
      if (state_d == ST_GNT_E) last_d = REQR_EXT;
   end

   always_comb begin
      brls_n_d   = (state_d == ST_IDLE || state_d == ST_RET);
      back_n_d   = (state_d != ST_GNT_S);
      exback_n_d = (state_d != ST_GNT_E);
      owner_d    = (state_d == ST_IDLE || state_d == ST_REQ) ? OWN_MST :
                   (state_d == ST_GNT_S) ? OWN_SLV :
                   (state_d == ST_GNT_E) ? OWN_EXT : OWN_NONE;
   end

   assign BRLS_N   = brls_n_q;
   assign BACK_N   = back_n_q;
   assign EXBACK_N = exback_n_q;
   assign OWNER    = owner_q;
   assign ARB_ERR  = arb_err_q;
endmodule
